// File: rtl/barrel_shift_arbiter_if.sv
// Request/response bundle for barrel_shift_arbiter: two command channels in,
// one tagged result channel out. master = requester/consumer side, slave = arbiter.
interface barrel_shift_arbiter_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned SHW   = 2
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_data;
    logic [SHW-1:0]   req0_amt;
    logic             req0_dir;
    logic             req0_ready;

    logic             req1_valid;
    logic [WIDTH-1:0] req1_data;
    logic [SHW-1:0]   req1_amt;
    logic             req1_dir;
    logic             req1_ready;

    logic             rsp_valid;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_id;
    logic             rsp_ready;

    modport master (
        output req0_valid, req0_data, req0_amt, req0_dir,
        input  req0_ready,
        output req1_valid, req1_data, req1_amt, req1_dir,
        input  req1_ready,
        input  rsp_valid, rsp_data, rsp_id,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_data, req0_amt, req0_dir,
        output req0_ready,
        input  req1_valid, req1_data, req1_amt, req1_dir,
        output req1_ready,
        output rsp_valid, rsp_data, rsp_id,
        input  rsp_ready
    );
endinterface

// File: rtl/barrel_shift_arbiter.sv
// Two-requester round-robin arbiter in front of one registered barrel shifter.
// Result is held in a single output register (EMPTY/FULL) that can drain and
// refill in the same cycle. Define ROTATE_EN to make shifts rotations instead
// of zero-filling logical shifts.
module barrel_shift_arbiter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned SHW   = 2
) (
    input logic                 clk,
    input logic                 rst,
    barrel_shift_arbiter_if.slave bus
);

    typedef enum logic {StEmpty, StFull} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rsp_data_q;
    logic             rsp_id_q;
    logic             last_grant_q;

    logic             slot_avail;
    logic             any_valid;
    logic             grant;
    logic             accept;
    logic [WIDTH-1:0] sel_data;
    logic [SHW-1:0]   sel_amt;
    logic             sel_dir;
    logic [WIDTH-1:0] shifted;

    function automatic logic [WIDTH-1:0] do_shift(input logic [WIDTH-1:0] data,
                                                  input logic [SHW-1:0]   amt,
                                                  input logic             dir);
`ifdef ROTATE_EN
        // Rotating a doubled copy lets one shifter cover both wrap directions.
        logic [2*WIDTH-1:0] dbl;
        dbl = {data, data};
        if (dir) begin
            dbl      = dbl >> amt;
            do_shift = dbl[WIDTH-1:0];
        end else begin
            dbl      = dbl << amt;
            do_shift = dbl[2*WIDTH-1:WIDTH];
        end
`else
        do_shift = dir ? (data >> amt) : (data << amt);
`endif
    endfunction

    // Arbitration and handshake: pick a winner, decide whether it is taken.
    always_comb begin
        slot_avail = (state_q == StEmpty) || bus.rsp_ready;
        any_valid  = bus.req0_valid || bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~last_grant_q;
        end else begin
            grant = bus.req1_valid;
        end
        // rst gating keeps readies low while reset is held, even though state is EMPTY.
        accept = slot_avail && any_valid && !rst;
    end

    // Mux the winning command into the shared shifter.
    always_comb begin
        sel_data = grant ? bus.req1_data : bus.req0_data;
        sel_amt  = grant ? bus.req1_amt  : bus.req0_amt;
        sel_dir  = grant ? bus.req1_dir  : bus.req0_dir;
        shifted  = do_shift(sel_data, sel_amt, sel_dir);
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: an accept always lands in FULL, a drain without refill empties.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StEmpty: begin
                if (accept) state_d = StFull;
            end
            StFull: begin
                if (accept) begin
                    state_d = StFull;
                end else if (bus.rsp_ready) begin
                    state_d = StEmpty;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    // FSM outputs.
    always_comb begin
        bus.rsp_valid  = (state_q == StFull);
        bus.rsp_data   = rsp_data_q;
        bus.rsp_id     = rsp_id_q;
        bus.req0_ready = accept && !grant;
        bus.req1_ready = accept && grant;
    end

    // Result register and round-robin history; data/id hold their value on drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_data_q   <= '0;
            rsp_id_q     <= 1'b0;
            last_grant_q <= 1'b1;
        end else if (accept) begin
            rsp_data_q   <= shifted;
            rsp_id_q     <= grant;
            last_grant_q <= grant;
        end
    end

endmodule

// File: tb/tb_barrel_shift_arbiter.sv
// Directed table-driven bench for barrel_shift_arbiter (WIDTH=4).
module tb_barrel_shift_arbiter;

    logic clk;
    logic rst;

    barrel_shift_arbiter_if #(.WIDTH(4), .SHW(2)) bus ();

    barrel_shift_arbiter #(.WIDTH(4), .SHW(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected values that differ between logical and rotate builds.
`ifdef ROTATE_EN
    localparam logic [3:0] E_1010_L1 = 4'b0101;
    localparam logic [3:0] E_1110_L3 = 4'b0111;
    localparam logic [3:0] E_1100_L2 = 4'b0011;
    localparam logic [3:0] E_1111_L3 = 4'b1111;
`else
    localparam logic [3:0] E_1010_L1 = 4'b0100;
    localparam logic [3:0] E_1110_L3 = 4'b0000;
    localparam logic [3:0] E_1100_L2 = 4'b0000;
    localparam logic [3:0] E_1111_L3 = 4'b1000;
`endif

    typedef struct {
        string      name;
        logic       v0;
        logic [3:0] d0;
        logic [1:0] a0;
        logic       dir0;
        logic       v1;
        logic [3:0] d1;
        logic [1:0] a1;
        logic       dir1;
        logic       rr;
        logic       chk_rdy;
        logic       e_rdy0;
        logic       e_rdy1;
        logic       e_valid;
        logic [3:0] e_data;
        logic       e_id;
    } vec_t;

    vec_t tbl[$];
    int   n_vec;
    int   n_bad;

    function automatic vec_t mk(input string name,
                                input logic v0, input logic [3:0] d0, input logic [1:0] a0,
                                input logic dir0,
                                input logic v1, input logic [3:0] d1, input logic [1:0] a1,
                                input logic dir1,
                                input logic rr, input logic chk_rdy,
                                input logic e_rdy0, input logic e_rdy1,
                                input logic e_valid, input logic [3:0] e_data,
                                input logic e_id);
        vec_t v;
        v.name = name; v.v0 = v0; v.d0 = d0; v.a0 = a0; v.dir0 = dir0;
        v.v1 = v1; v.d1 = d1; v.a1 = a1; v.dir1 = dir1; v.rr = rr;
        v.chk_rdy = chk_rdy; v.e_rdy0 = e_rdy0; v.e_rdy1 = e_rdy1;
        v.e_valid = e_valid; v.e_data = e_data; v.e_id = e_id;
        return v;
    endfunction

    task automatic chk4(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.req0_valid = v.v0;
        bus.req0_data  = v.d0;
        bus.req0_amt   = v.a0;
        bus.req0_dir   = v.dir0;
        bus.req1_valid = v.v1;
        bus.req1_data  = v.d1;
        bus.req1_amt   = v.a1;
        bus.req1_dir   = v.dir1;
        bus.rsp_ready  = v.rr;
    endtask

    initial begin
        vec_t idle;
        n_vec = 0;
        n_bad = 0;

        // Contention right after reset: grants 0,1,0,1 with no bubbles.
        tbl.push_back(mk("c1", 1, 4'b0001, 2'd1, 0, 1, 4'b1000, 2'd1, 1, 1, 1, 1, 0, 1, 4'b0010, 0));
        tbl.push_back(mk("c2", 1, 4'b0001, 2'd1, 0, 1, 4'b1000, 2'd1, 1, 1, 1, 0, 1, 1, 4'b0100, 1));
        tbl.push_back(mk("c3", 1, 4'b0001, 2'd1, 0, 1, 4'b1000, 2'd1, 1, 1, 1, 1, 0, 1, 4'b0010, 0));
        tbl.push_back(mk("c4", 1, 4'b0001, 2'd1, 0, 1, 4'b1000, 2'd1, 1, 1, 1, 0, 1, 1, 4'b0100, 1));
        // Backpressure: result held, nothing accepted, payloads change meanwhile.
        tbl.push_back(mk("b1", 1, 4'b0011, 2'd2, 0, 1, 4'b0110, 2'd1, 1, 0, 1, 0, 0, 1, 4'b0100, 1));
        tbl.push_back(mk("b2", 1, 4'b0011, 2'd2, 0, 1, 4'b0110, 2'd1, 1, 0, 1, 0, 0, 1, 4'b0100, 1));
        tbl.push_back(mk("b3", 1, 4'b0011, 2'd2, 0, 1, 4'b0110, 2'd1, 1, 0, 1, 0, 0, 1, 4'b0100, 1));
        tbl.push_back(mk("b4", 1, 4'b0011, 2'd2, 0, 1, 4'b0110, 2'd1, 1, 1, 1, 1, 0, 1, 4'b1100, 0));
        tbl.push_back(mk("b5", 0, 4'b0000, 2'd0, 0, 1, 4'b0110, 2'd1, 1, 1, 1, 0, 1, 1, 4'b0011, 1));
        tbl.push_back(mk("d1", 0, 4'b0000, 2'd0, 0, 0, 4'b0000, 2'd0, 0, 1, 0, 0, 0, 0, 4'b0011, 1));
        // Single-requester shifts and boundaries.
        tbl.push_back(mk("s1", 1, 4'b1010, 2'd1, 0, 0, 4'b0000, 2'd0, 0, 0, 1, 1, 0, 1, E_1010_L1, 0));
        tbl.push_back(mk("s2", 1, 4'b1010, 2'd1, 1, 0, 4'b0000, 2'd0, 0, 1, 1, 1, 0, 1, 4'b0101, 0));
        tbl.push_back(mk("s3", 0, 4'b0000, 2'd0, 0, 0, 4'b0000, 2'd0, 0, 1, 0, 0, 0, 0, 4'b0101, 0));
        tbl.push_back(mk("s4", 0, 4'b0000, 2'd0, 0, 1, 4'b1110, 2'd3, 0, 0, 1, 0, 1, 1, E_1110_L3, 1));
        tbl.push_back(mk("s5", 0, 4'b0000, 2'd0, 0, 1, 4'b1100, 2'd2, 1, 1, 1, 0, 1, 1, 4'b0011, 1));
        tbl.push_back(mk("s6", 1, 4'b1100, 2'd2, 0, 0, 4'b0000, 2'd0, 0, 1, 1, 1, 0, 1, E_1100_L2, 0));
        tbl.push_back(mk("s7", 1, 4'b1011, 2'd0, 0, 0, 4'b0000, 2'd0, 0, 1, 1, 1, 0, 1, 4'b1011, 0));
        tbl.push_back(mk("s8", 0, 4'b0000, 2'd0, 0, 1, 4'b1011, 2'd0, 1, 1, 1, 0, 1, 1, 4'b1011, 1));
        tbl.push_back(mk("s9", 1, 4'b1111, 2'd3, 0, 0, 4'b0000, 2'd0, 0, 1, 1, 1, 0, 1, E_1111_L3, 0));
        tbl.push_back(mk("s10", 0, 4'b0000, 2'd0, 0, 0, 4'b0000, 2'd0, 0, 1, 0, 0, 0, 0, E_1111_L3, 0));

        idle = mk("idle", 0, 4'b0, 2'd0, 0, 0, 4'b0, 2'd0, 0, 0, 0, 0, 0, 0, 4'b0, 0);
        drive(idle);
        rst = 1'b0;
        #1 rst = 1'b1;
        // Reset values, with a requester pushing so the ready gating is exercised.
        #1 bus.req0_valid = 1'b1;
        bus.rsp_ready = 1'b1;
        #1;
        chk1("rst_valid", bus.rsp_valid, 1'b0);
        chk4("rst_data", bus.rsp_data, 4'b0000);
        chk1("rst_id", bus.rsp_id, 1'b0);
        chk1("rst_rdy0", bus.req0_ready, 1'b0);
        chk1("rst_rdy1", bus.req1_ready, 1'b0);
        @(negedge clk);
        drive(idle);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            if (i != 0) @(negedge clk);
            drive(tbl[i]);
            #1;
            if (tbl[i].chk_rdy) begin
                chk1({tbl[i].name, "_rdy0"}, bus.req0_ready, tbl[i].e_rdy0);
                chk1({tbl[i].name, "_rdy1"}, bus.req1_ready, tbl[i].e_rdy1);
            end
            @(posedge clk);
            #1;
            chk1({tbl[i].name, "_valid"}, bus.rsp_valid, tbl[i].e_valid);
            chk4({tbl[i].name, "_data"}, bus.rsp_data, tbl[i].e_data);
            chk1({tbl[i].name, "_id"}, bus.rsp_id, tbl[i].e_id);
        end

        // Reset while FULL under backpressure; last grant was 0 before reset.
        @(negedge clk);
        drive(mk("r0", 1, 4'b0001, 2'd0, 0, 0, 4'b0, 2'd0, 0, 0, 0, 0, 0, 0, 4'b0, 0));
        @(posedge clk);
        #1;
        chk1("r_full_valid", bus.rsp_valid, 1'b1);
        chk4("r_full_data", bus.rsp_data, 4'b0001);
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        rst = 1'b1;
        #1;
        chk1("r_async_valid", bus.rsp_valid, 1'b0);
        chk4("r_async_data", bus.rsp_data, 4'b0000);
        chk1("r_async_id", bus.rsp_id, 1'b0);
        chk1("r_async_rdy0", bus.req0_ready, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        drive(mk("r1", 1, 4'b0010, 2'd1, 0, 1, 4'b0100, 2'd1, 1, 1, 0, 0, 0, 0, 4'b0, 0));
        #1;
        chk1("r_post_rdy0", bus.req0_ready, 1'b1);
        chk1("r_post_rdy1", bus.req1_ready, 1'b0);
        @(posedge clk);
        #1;
        chk1("r_post_valid", bus.rsp_valid, 1'b1);
        chk1("r_post_id", bus.rsp_id, 1'b0);
        chk4("r_post_data", bus.rsp_data, 4'b0100);
        @(negedge clk);
        #1;
        chk1("r_next_rdy1", bus.req1_ready, 1'b1);
        @(posedge clk);
        #1;
        chk1("r_next_id", bus.rsp_id, 1'b1);
        chk4("r_next_data", bus.rsp_data, 4'b0010);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
